// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 7-segment scan driver:
//               active-low segment type, dark pattern and hex decode table.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment vector, bit order {g,f,e,d,c,b,a}
    typedef logic [6:0] seg7_t;

    // All segments off
    localparam seg7_t SEG_OFF = 7'h7F;

    // Hex digit to active-low segment pattern, index = nibble value
    localparam seg7_t HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_if
// Description : Display-value inputs and board-pin outputs of the scan driver.
//               master = value source / pin observer, slave = seg7_scan.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic [DIGITS-1:0]   an_out;

    modport master (
        output value, dp_in, blank,
        input  seg_out, dp_out, an_out
    );

    modport slave (
        input  value, dp_in, blank,
        output seg_out, dp_out, an_out
    );
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational hex nibble to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  wire logic [3:0] nibble,
    output seg7_t           seg
);

    // Straight table lookup; every nibble value has an entry
    always_comb begin
        seg = HEX_TABLE[nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : Time-multiplexed common-anode 7-segment driver. Prescales the
//               clock into digit slots, latches the display value once per
//               frame and blanks all anodes for GUARD cycles at each slot start.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 256,
    parameter int GUARD    = 8
) (
    input  wire logic   sys_clock,
    input  wire logic   reset,
    seg7_scan_if.slave  bus
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DW   = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(SCAN_DIV - 1);
    localparam logic [DIVW-1:0] GUARD_END  = DIVW'(GUARD);
    localparam logic [DW-1:0]   DIGIT_LAST = DW'(DIGITS - 1);

    logic [DIVW-1:0]     r_div;
    logic [DW-1:0]       r_digit;
    logic [4*DIGITS-1:0] r_shadow_value;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [DIGITS-1:0]   r_shadow_blank;
    seg7_t               r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_tick;
    logic [3:0]          w_nibble;
    logic                w_sel_dp;
    logic                w_sel_blank;
    logic                w_sel_supp;
    logic                w_digit_ok;
    logic                w_dark;
    logic [DIGITS-1:0]   w_suppress;
    seg7_t               w_seg;

    assign w_tick = (r_div == DIV_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_run;

    // Walk down from the top digit darkening zeros until a nonzero nibble or lit dp
    always_comb begin
        w_suppress = '0;
        w_run      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_run && (r_shadow_value[i*4 +: 4] == 4'h0) && !r_shadow_dp[i]) begin
                w_suppress[i] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end
`else
    assign w_suppress = '0;
`endif

    // Select the active digit's shadow fields; an unmatched digit stays dark
    always_comb begin
        w_nibble    = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b1;
        w_sel_supp  = 1'b0;
        w_digit_ok  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == DW'(i)) begin
                w_nibble    = r_shadow_value[i*4 +: 4];
                w_sel_dp    = r_shadow_dp[i];
                w_sel_blank = r_shadow_blank[i];
                w_sel_supp  = w_suppress[i];
                w_digit_ok  = 1'b1;
            end
        end
    end

    assign w_dark = !w_digit_ok || (r_div < GUARD_END) || w_sel_blank || w_sel_supp;

    seg7_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    // Prescaler, digit counter, frame latch and registered pin drivers
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_div          <= '0;
            r_digit        <= '0;
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '1;
            r_seg          <= SEG_OFF;
            r_dp           <= 1'b1;
            r_an           <= '1;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;

            if (w_tick) begin
                r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;
            end

            // Whole display value captured at frame end so a frame never tears
            if (w_tick && (r_digit == DIGIT_LAST)) begin
                r_shadow_value <= bus.value;
                r_shadow_dp    <= bus.dp_in;
                r_shadow_blank <= bus.blank;
            end

            if (w_dark) begin
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                r_seg <= w_seg;
                r_dp  <= ~w_sel_dp;
                r_an  <= ~(DIGITS'(1) << r_digit);
            end
        end
    end

    assign bus.seg_out = r_seg;
    assign bus.dp_out  = r_dp;
    assign bus.an_out  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Randomised scoreboard bench for seg7_scan (DIGITS=4,
//               SCAN_DIV=4, GUARD=1). A time-based reference model predicts
//               the pins each cycle; a monitor compares on the falling edge.
//               Honours SEG7_LEADING_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * SD;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
    } pins_t;

    logic clk;
    logic reset;

    seg7_scan_if #(.DIGITS(ND)) bus ();

    seg7_scan #(
        .DIGITS   (ND),
        .SCAN_DIV (SD),
        .GUARD    (GD)
    ) dut (
        .sys_clock (clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] ref_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks = 0;
    int errors = 0;

    pins_t exp_q [$];

    // Reference model state: cycles since reset release and latched frame
    int unsigned     mt = 0;
    logic [4*ND-1:0] lv = '0;
    logic [ND-1:0]   ldp = '0;
    logic [ND-1:0]   lbl = '1;

    function automatic bit is_suppressed(int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic [4*ND-1:0] v;
        v = lv;
        if (d == 0) return 1'b0;
        for (int j = ND - 1; j >= d; j--) begin
            if (v[j*4 +: 4] != 4'h0 || ldp[j]) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic pins_t predict(int d, int pos);
        pins_t p;
        logic [4*ND-1:0] v;
        v = lv;
        if (pos < GD || lbl[d] || is_suppressed(d)) begin
            p.seg = 7'h7F;
            p.dp  = 1'b1;
            p.an  = '1;
        end else begin
            p.seg = ref_tab[v[d*4 +: 4]];
            p.dp  = ~ldp[d];
            p.an  = '1;
            p.an[d] = 1'b0;
        end
        return p;
    endfunction

    // Model: predict the pins that appear after this edge from the slot
    // position implied by elapsed time, then advance time
    always @(posedge clk) begin
        int pos;
        int d;
        if (reset) begin
            exp_q.push_back('{seg: 7'h7F, dp: 1'b1, an: '1});
            mt  = 0;
            lv  = '0;
            ldp = '0;
            lbl = '1;
        end else begin
            pos = int'(mt % SD);
            d   = int'((mt / SD) % ND);
            exp_q.push_back(predict(d, pos));
            if (pos == SD - 1 && d == ND - 1) begin
                lv  = bus.value;
                ldp = bus.dp_in;
                lbl = bus.blank;
            end
            mt++;
        end
    end

    // Monitor: compare every presented pin state against the scoreboard
    always @(negedge clk) begin
        pins_t got;
        pins_t exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = '{seg: bus.seg_out, dp: bus.dp_out, an: bus.an_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pins t=%0t mt=%0d got seg=%h dp=%b an=%b expected seg=%h dp=%b an=%b",
                         $time, mt, got.seg, got.dp, got.an, exp.seg, exp.dp, exp.an);
            end
            checks++;
            if (got.an != '1 && $countones(~got.an) != 1) begin
                errors++;
                $display("FAIL one_anode got an=%b expected at most one low bit", got.an);
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until the model sits at the given cycle within the frame
    task automatic wait_phase(int ph);
        int k;
        k = 0;
        while (int'(mt % FRAME) != ph && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        if (int'(mt % FRAME) != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase got phase=%0d expected %0d", mt % FRAME, ph);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.value = 16'h1234;
        bus.dp_in = '0;
        bus.blank = '0;
        cycles(5);
        reset = 1'b0;
        cycles(3 * FRAME);

        bus.value = 16'h8F01;
        cycles(3 * FRAME);

        bus.value = 16'h1111;
        cycles(FRAME);
        wait_phase(SD + 1);
        bus.value = 16'h2222;
        cycles(2 * FRAME);

        bus.value = 16'h0000;
        bus.blank = 4'b0100;
        bus.dp_in = 4'b0001;
        cycles(3 * FRAME);

        bus.blank = '0;
        bus.dp_in = '0;
        bus.value = 16'hA5C3;
        cycles(FRAME);
        wait_phase(2 * SD + 2);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(3 * FRAME);

        bus.value = 16'h0050;
        cycles(3 * FRAME);
        bus.value = 16'h0000;
        cycles(3 * FRAME);
        bus.value = 16'h0004;
        bus.dp_in = 4'b0100;
        cycles(3 * FRAME);

        for (int it = 0; it < 150; it++) begin
            bus.value = 16'($urandom);
            bus.dp_in = 4'($urandom_range(0, 15));
            bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if ($urandom_range(0, 2) == 0) begin
                bus.value[15:8] = 8'h00;
                bus.dp_in       = 4'h0;
            end
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 3));
                reset = 1'b0;
            end
            cycles($urandom_range(1, 24));
        end
        cycles(2 * FRAME);

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected <=1", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Output-side board driver: time-multiplexes DIGITS hex nibbles onto one shared common-anode 7-segment bus.
- Counterpart of the debounced switch input path. Switches bring values in; this block displays values out.
- Sits between core/debug registers and the board pins.
- Divides sys_clock into a digit-scan tick, latches the whole display value once per frame (no tearing), and inserts an anode-off guard at each digit change (no ghosting).

Parameters:
- DIGITS, 4: number of multiplexed digits (2..8).
- SCAN_DIV, 256: sys_clock cycles per digit slot (>= GUARD+2).
- GUARD, 8: cycles at the start of each slot with all anodes off (>= 1).

Ports:
- sys_clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost, value[3:0]).
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank  in  DIGITS  per-digit force-dark, 1 = dark.
- seg_out  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1  decimal point, active-low.
- an_out  out  DIGITS  digit anode enables, active-low; at most one bit is 0.

Behaviour:
- Single clock domain (sys_clock). Reset is synchronous, active-high, and dominates everything; reset asserted mid-frame aborts the scan with no residual glitch.
- Reset values:
  - div=0, digit=0.
  - shadow_value=0, shadow_dp=0, shadow_blank all 1.
  - seg_out=7'h7F, dp_out=1, an_out all 1.
- Prescaler div counts 0..SCAN_DIV-1 and wraps. tick is high when div==SCAN_DIV-1.
- On tick, digit advances to digit+1, wrapping DIGITS-1 -> 0.
- Frame latch: on the tick where digit==DIGITS-1, shadow_value/shadow_dp/shadow_blank <= value/dp_in/blank.
  - Inputs are sampled only then. Changes mid-frame appear at the next frame.
  - After reset, all digits are dark until the first frame latch (DIGITS*SCAN_DIV cycles after reset deassert).
- Output registers are updated every cycle from the current div/digit/shadow: one-cycle latency.
  - If div < GUARD, or shadow_blank[digit]=1: an_out all 1, seg_out=7'h7F, dp_out=1.
  - Otherwise: an_out = ~(1<<digit), seg_out = decode(shadow_value nibble[digit]), dp_out = ~shadow_dp[digit].
- Decode (active-low {g..a}), fixed table:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex)
- No X or undefined states. Values of digit >= DIGITS are unreachable; they decode as dark.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digits from DIGITS-1 downward whose shadow nibble is 0 are dark, up to the first nonzero nibble.
  - Digit 0 is never suppressed.
  - A digit with dp lit is not suppressed, and stops suppression below it.
  - Suppression is computed from shadow registers only.
- Not defined: all non-blanked digits display, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF (7'h7F) constant.
  - Active-low segment typedef (logic [6:0]).
  - 16-entry hex-to-segment constant table.
- Sub-module seg7_decode: purely combinational nibble -> segments, instanced once, fed by the muxed shadow nibble.
- Prescaler, digit counter, shadow registers and output registers stay in seg7_scan.

Test Plan (DIGITS=4, SCAN_DIV=4, GUARD=1 unless noted):
- Reset hold 5 cycles, value=16'h1234 -> an_out=4'hF, seg_out=7'h7F, dp_out=1 throughout, and for the first 16 cycles after release; then in digit-0 slot an_out=4'b1110, seg_out=7'h19.
- value=16'h8F01 steady for 3 frames -> per-slot seg_out 79,40,0E,00 on an_out 1110,1101,1011,0111; each slot's first cycle is all-dark guard.
- value changed 16'h1111->16'h2222 mid-frame (digit 1 slot) -> remaining slots still show 79; the next frame shows 24 on all digits.
- blank=4'b0100, dp_in=4'b0001, value=16'h0000 -> digit 2 slot all dark; digit 0 shows seg 40 with dp_out=0; never two an_out bits low.
- Reset asserted 2 cycles mid-slot of digit 2 -> outputs dark the cycle after; div and digit restart at 0; shadow_blank all 1 until the next frame latch.
- SEG7_LEADING_ZERO_BLANK_EN defined, value=16'h0050 -> digits 3 and 2 dark; digit 1 shows 12, digit 0 shows 40. With value=16'h0000 only digit 0 lit (40).
